// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline boundary: default sizes,
// FSM state encoding and the packed bundle width.
package ex_mem_pkg;

  localparam int unsigned XLEN_D   = 32;
  localparam int unsigned NUM_FU_D = 3;
  localparam int unsigned OP_W_D   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Bundle layout, MSB first: tunnel, rd_result, pc, op_write, op_read, op.
  function automatic int unsigned bundle_w(input int unsigned num_fu, input int unsigned xlen,
                                           input int unsigned op_w);
    return num_fu + 2 * num_fu * xlen + 2 + op_w;
  endfunction

  localparam int unsigned BUNDLE_W = bundle_w(NUM_FU_D, XLEN_D, OP_W_D);

endpackage

// File: rtl/ex_mem_slot.sv
// One bundle-wide storage slot with load enable, synchronous clear and lane
// gating (results/PCs of lanes without their tunnel bit are stored as zero).
module ex_mem_slot
  import ex_mem_pkg::*;
#(
  parameter int unsigned NUM_FU = NUM_FU_D,
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned OP_W   = OP_W_D,
  localparam int unsigned BW    = bundle_w(NUM_FU, XLEN, OP_W)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          clear,
  input  logic [BW-1:0] d,
  output logic [BW-1:0] q
);

  localparam int unsigned PcLsb  = OP_W + 2;
  localparam int unsigned ResLsb = PcLsb + NUM_FU * XLEN;
  localparam int unsigned TunLsb = ResLsb + NUM_FU * XLEN;

  logic [BW-1:0] gated;

  always_comb begin
    gated = d;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (!d[TunLsb+i]) begin
        gated[PcLsb+i*XLEN +: XLEN]  = '0;
        gated[ResLsb+i*XLEN +: XLEN] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= gated;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline boundary: valid/ready register with a 2-entry skid buffer,
// registered in_ready and synchronous flush.
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int unsigned NUM_FU = NUM_FU_D,
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned OP_W   = OP_W_D
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_FU-1:0]      tunnel_in,
  input  logic [NUM_FU*XLEN-1:0] rd_result_in,
  input  logic [NUM_FU*XLEN-1:0] pc_in,
  input  logic                   op_write_in,
  input  logic                   op_read_in,
  input  logic [OP_W-1:0]        op_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_FU-1:0]      tunnel_out,
  output logic [NUM_FU*XLEN-1:0] rd_result_out,
  output logic [NUM_FU*XLEN-1:0] pc_out,
  output logic                   op_write_out,
  output logic                   op_read_out,
  output logic [OP_W-1:0]        op_out
);

  localparam int unsigned BW = bundle_w(NUM_FU, XLEN, OP_W);

  state_e        state_q, state_d;
  logic          in_ready_q;
  logic          accept, drain;
  logic          main_load, main_clear, main_from_skid, skid_load, skid_clear;
  logic [BW-1:0] in_bundle, main_d, main_q, skid_q;

  assign in_bundle = {tunnel_in, rd_result_in, pc_in, op_write_in, op_read_in, op_in};
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;
  assign main_d    = main_from_skid ? skid_q : in_bundle;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          skid_load = 1'b1;
        end else if (drain) begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d        = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any accept/drain bookkeeping this cycle.
    if (flush) begin
      state_d    = ST_EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  ex_mem_slot #(
    .NUM_FU(NUM_FU),
    .XLEN  (XLEN),
    .OP_W  (OP_W)
  ) u_main (
    .clk  (clk),
    .rstn (rstn),
    .load (main_load),
    .clear(main_clear),
    .d    (main_d),
    .q    (main_q)
  );

  ex_mem_slot #(
    .NUM_FU(NUM_FU),
    .XLEN  (XLEN),
    .OP_W  (OP_W)
  ) u_skid (
    .clk  (clk),
    .rstn (rstn),
    .load (skid_load),
    .clear(skid_clear),
    .d    (in_bundle),
    .q    (skid_q)
  );

  assign {tunnel_out, rd_result_out, pc_out, op_write_out, op_read_out, op_out} = main_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Randomised and directed bench for ex_mem_pipe_reg against a 2-deep queue model.
module tb_ex_mem_pipe_reg;
  localparam int unsigned NF = 3;
  localparam int unsigned X  = 32;
  localparam int unsigned OW = 4;

  typedef struct packed {
    logic [NF-1:0]   tunnel;
    logic [NF*X-1:0] res;
    logic [NF*X-1:0] pc;
    logic            wr;
    logic            rd;
    logic [OW-1:0]   op;
  } bundle_t;

  logic            clk = 1'b0;
  logic            rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [NF-1:0]   tunnel_out;
  logic [NF*X-1:0] rd_result_out, pc_out;
  logic            op_write_out, op_read_out;
  logic [OW-1:0]   op_out;
  bundle_t         cur;

  int      checks = 0;
  int      errors = 0;
  bundle_t model_q[$];
  logic    m_ready;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(
    .NUM_FU(NF),
    .XLEN  (X),
    .OP_W  (OW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tunnel_in    (cur.tunnel),
    .rd_result_in (cur.res),
    .pc_in        (cur.pc),
    .op_write_in  (cur.wr),
    .op_read_in   (cur.rd),
    .op_in        (cur.op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .tunnel_out   (tunnel_out),
    .rd_result_out(rd_result_out),
    .pc_out       (pc_out),
    .op_write_out (op_write_out),
    .op_read_out  (op_read_out),
    .op_out       (op_out)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bundle_t gate(input bundle_t b);
    bundle_t g = b;
    for (int i = 0; i < int'(NF); i++) begin
      if (!b.tunnel[i]) begin
        g.res[i*X +: X] = '0;
        g.pc[i*X +: X]  = '0;
      end
    end
    return g;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.tunnel = NF'($urandom);
    for (int i = 0; i < int'(NF); i++) begin
      b.res[i*X +: X] = $urandom;
      b.pc[i*X +: X]  = $urandom;
    end
    b.wr = 1'($urandom);
    b.rd = 1'($urandom);
    b.op = OW'($urandom);
    return b;
  endfunction

  task automatic check_outputs();
    bundle_t e;
    e = (model_q.size() != 0) ? model_q[0] : '0;
    check_eq("out_valid", 256'(out_valid), 256'(model_q.size() != 0));
    check_eq("in_ready", 256'(in_ready), 256'(m_ready));
    check_eq("tunnel_out", 256'(tunnel_out), 256'(e.tunnel));
    check_eq("rd_result_out", 256'(rd_result_out), 256'(e.res));
    check_eq("pc_out", 256'(pc_out), 256'(e.pc));
    check_eq("ctrl_out", 256'({op_write_out, op_read_out, op_out}), 256'({e.wr, e.rd, e.op}));
  endtask

  // Queue semantics: drain pops the head, accept appends, flush empties.
  task automatic model_step();
    logic acc, drn;
    acc = in_valid & m_ready;
    drn = (model_q.size() != 0) & out_ready;
    if (flush) begin
      model_q.delete();
    end else begin
      if (drn) void'(model_q.pop_front());
      if (acc) model_q.push_back(gate(cur));
    end
    m_ready = (model_q.size() < 2);
  endtask

  task automatic cycle(input bundle_t b, input logic v, input logic ordy, input logic fl);
    @(negedge clk);
    check_outputs();
    cur       = b;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step();
  endtask

  bundle_t a, bb;

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rstn = 1'b1;
    @(posedge clk);
    model_step();

    // Single pass with lane 1 gated off.
    a        = '0;
    a.tunnel = 3'b101;
    a.res    = {32'h33, 32'h22, 32'h11};
    a.pc     = {32'h108, 32'h104, 32'h100};
    a.rd     = 1'b1;
    a.op     = 4'h2;
    cycle(a, 1'b1, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);

    // Backpressure into skid, stall, then drain in order.
    a  = rand_bundle();
    bb = rand_bundle();
    cycle(a, 1'b1, 1'b0, 1'b0);
    cycle(bb, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(rand_bundle(), 1'b1, 1'b0, 1'b0);
    repeat (4) cycle('0, 1'b0, 1'b1, 1'b0);

    // Full throughput with incrementing PCs.
    for (int i = 0; i < 20; i++) begin
      a        = rand_bundle();
      a.tunnel = 3'b111;
      a.pc     = {32'(4 * i + 8), 32'(4 * i + 4), 32'(4 * i)};
      cycle(a, 1'b1, 1'b1, 1'b0);
    end
    repeat (2) cycle('0, 1'b0, 1'b1, 1'b0);

    // Flush in the TWO state with a simultaneous incoming bundle.
    cycle(rand_bundle(), 1'b1, 1'b0, 1'b0);
    cycle(rand_bundle(), 1'b1, 1'b0, 1'b0);
    cycle(rand_bundle(), 1'b1, 1'b0, 1'b1);
    repeat (2) cycle('0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while stalled in TWO.
    cycle(rand_bundle(), 1'b1, 1'b0, 1'b0);
    cycle(rand_bundle(), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    model_q.delete();
    m_ready = 1'b1;
    check_outputs();
    #1 rstn = 1'b1;
    @(posedge clk);
    model_step();
    cycle(rand_bundle(), 1'b1, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(rand_bundle(), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 15) == 0));
    end
    repeat (3) cycle('0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
